// File: rtl/clock_set_pkg.sv
// Shared types and constants for the clock time-set controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_set_pkg;

    // Controller states: free-running, editing one field, or the three-cycle commit burst.
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        SET_SEC = 3'd3,
        LD_SEC  = 3'd4,
        LD_MIN  = 3'd5,
        LD_HR   = 3'd6
    } state_t;

    // Load-target / field codes, shared by mode and Field outputs.
    localparam logic [1:0] MODE_NONE = 2'd0;
    localparam logic [1:0] MODE_SEC  = 2'd1;
    localparam logic [1:0] MODE_MIN  = 2'd2;
    localparam logic [1:0] MODE_HR   = 2'd3;

    localparam int SEC_LIMIT_DEF = 60;
    localparam int MIN_LIMIT_DEF = 60;
    localparam int HR_LIMIT_DEF  = 24;

endpackage

// File: rtl/time_set_controller_if.sv
// Button, live-counter and load-bus bundle between the time-set controller and its environment.
// Latency: n/a (wiring only).
// Backpressure: none; load is a fire-and-forget strobe.
// Ports: Btn_* raw buttons, Cur_* live counter values, Enable/load/mode/value/Field controller outputs.
interface time_set_controller_if #(
    parameter int WIDTH = 6
);
    logic             Btn_Set;
    logic             Btn_Inc;
    logic             Btn_Dec;
    logic             Btn_Ok;
    logic [WIDTH-1:0] Cur_Sec;
    logic [WIDTH-1:0] Cur_Min;
    logic [WIDTH-1:0] Cur_Hr;
    logic             Enable;
    logic             load;
    logic [1:0]       mode;
    logic [WIDTH-1:0] value;
    logic [1:0]       Field;

    // Environment side: drives buttons and counter values, observes the controller.
    modport master (
        output Btn_Set, Btn_Inc, Btn_Dec, Btn_Ok, Cur_Sec, Cur_Min, Cur_Hr,
        input  Enable, load, mode, value, Field
    );

    // Controller side.
    modport slave (
        input  Btn_Set, Btn_Inc, Btn_Dec, Btn_Ok, Cur_Sec, Cur_Min, Cur_Hr,
        output Enable, load, mode, value, Field
    );
endinterface

// File: rtl/button_edge.sv
// Synchronizes a raw button and emits a one-cycle pulse on its rising edge.
// Latency: pulse is high 3 cycles after the raw rise (2 sync flops + registered edge detect).
// Backpressure: none; a held button yields exactly one pulse.
// Ports: Clk, Clr (sync active-high), btn_raw in, pulse out.
module button_edge (
    input  logic Clk,
    input  logic Clr,
    input  logic btn_raw,
    output logic pulse
);
    logic sync0;
    logic sync1;
    logic prev;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync0 <= btn_raw;
            sync1 <= sync0;
            prev  <= sync1;
            pulse <= sync1 & ~prev;
        end
    end
endmodule

// File: rtl/time_set_controller.sv
// Lets the user stop the clock, edit hours/minutes/seconds with buttons, then load them back.
// Latency: outputs registered; commit burst starts the cycle after the Ok event, one field per cycle.
// Backpressure: none; buttons are ignored while the commit burst runs.
// Ports: Clk, Clr (sync active-high), bus (slave modport: buttons, Cur_*, Enable/load/mode/value/Field).
module time_set_controller
    import clock_set_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int SEC_LIMIT = SEC_LIMIT_DEF,
    parameter int MIN_LIMIT = MIN_LIMIT_DEF,
    parameter int HR_LIMIT  = HR_LIMIT_DEF
) (
    input  logic                  Clk,
    input  logic                  Clr,
    time_set_controller_if.slave  bus
);
    logic set_ev, inc_ev, dec_ev, ok_ev;

    button_edge u_set (.Clk(Clk), .Clr(Clr), .btn_raw(bus.Btn_Set), .pulse(set_ev));
    button_edge u_inc (.Clk(Clk), .Clr(Clr), .btn_raw(bus.Btn_Inc), .pulse(inc_ev));
    button_edge u_dec (.Clk(Clk), .Clr(Clr), .btn_raw(bus.Btn_Dec), .pulse(dec_ev));
    button_edge u_ok  (.Clk(Clk), .Clr(Clr), .btn_raw(bus.Btn_Ok),  .pulse(ok_ev));

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sec_r, min_r, hr_r;
    logic [WIDTH-1:0] sec_nxt, min_nxt, hr_nxt;
    logic             en_q, load_q, en_nxt, load_nxt;
    logic [1:0]       mode_q, field_q, mode_nxt, field_nxt;
    logic [WIDTH-1:0] value_q, value_nxt;

    // Modular +/-1; Inc and Dec together cancel.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input int lim,
                                              input logic up, input logic dn);
        logic [WIDTH-1:0] r;
        r = v;
        if (up && !dn)
            r = (32'(v) == 32'(lim - 1)) ? '0 : v + 1'b1;
        else if (dn && !up)
            r = (v == '0) ? WIDTH'(lim - 1) : v - 1'b1;
        return r;
    endfunction

    // Live values outside the field range are replaced by 0 so edit registers stay legal.
    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v, input int lim);
        return (32'(v) < 32'(lim)) ? v : '0;
    endfunction

    always_comb begin
        state_nxt = state;
        sec_nxt   = sec_r;
        min_nxt   = min_r;
        hr_nxt    = hr_r;
        case (state)
            RUN: begin
                if (set_ev) begin
                    state_nxt = SET_HR;
                    sec_nxt   = clamp(bus.Cur_Sec, SEC_LIMIT);
                    min_nxt   = clamp(bus.Cur_Min, MIN_LIMIT);
                    hr_nxt    = clamp(bus.Cur_Hr, HR_LIMIT);
                end
            end
            SET_HR, SET_MIN, SET_SEC: begin
                // Ok wins over everything; Set wins over an edit in the same cycle.
                if (ok_ev) begin
                    state_nxt = LD_SEC;
                end else if (set_ev) begin
                    state_nxt = (state == SET_HR)  ? SET_MIN :
                                (state == SET_MIN) ? SET_SEC : SET_HR;
                end else begin
                    if (state == SET_HR)  hr_nxt  = step(hr_r,  HR_LIMIT,  inc_ev, dec_ev);
                    if (state == SET_MIN) min_nxt = step(min_r, MIN_LIMIT, inc_ev, dec_ev);
                    if (state == SET_SEC) sec_nxt = step(sec_r, SEC_LIMIT, inc_ev, dec_ev);
                end
            end
            LD_SEC:  state_nxt = LD_MIN;
            LD_MIN:  state_nxt = LD_HR;
            LD_HR:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase

        // Outputs are a function of the next state so they can be registered alongside it.
        en_nxt    = 1'b0;
        load_nxt  = 1'b0;
        mode_nxt  = MODE_NONE;
        value_nxt = '0;
        field_nxt = MODE_NONE;
        case (state_nxt)
            RUN:     en_nxt    = 1'b1;
            SET_HR:  field_nxt = MODE_HR;
            SET_MIN: field_nxt = MODE_MIN;
            SET_SEC: field_nxt = MODE_SEC;
            LD_SEC:  begin load_nxt = 1'b1; mode_nxt = MODE_SEC; value_nxt = sec_nxt; end
            LD_MIN:  begin load_nxt = 1'b1; mode_nxt = MODE_MIN; value_nxt = min_nxt; end
            LD_HR:   begin load_nxt = 1'b1; mode_nxt = MODE_HR;  value_nxt = hr_nxt;  end
            default: en_nxt    = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state   <= RUN;
            sec_r   <= '0;
            min_r   <= '0;
            hr_r    <= '0;
            en_q    <= 1'b1;
            load_q  <= 1'b0;
            mode_q  <= MODE_NONE;
            value_q <= '0;
            field_q <= MODE_NONE;
        end else begin
            state   <= state_nxt;
            sec_r   <= sec_nxt;
            min_r   <= min_nxt;
            hr_r    <= hr_nxt;
            en_q    <= en_nxt;
            load_q  <= load_nxt;
            mode_q  <= mode_nxt;
            value_q <= value_nxt;
            field_q <= field_nxt;
        end
    end

    assign bus.Enable = en_q;
    assign bus.load   = load_q;
    assign bus.mode   = mode_q;
    assign bus.value  = value_q;
    assign bus.Field  = field_q;
endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with a load-pulse scoreboard.
// Latency: button press helper returns once the FSM has reacted (4 edges after the raw rise).
// Backpressure: n/a.
module tb_time_set_controller;
    import clock_set_pkg::*;

    localparam int W = 6;

    logic Clk = 1'b0;
    logic Clr = 1'b1;
    always #5 Clk = ~Clk;

    time_set_controller_if #(.WIDTH(W)) bus ();

    time_set_controller #(.WIDTH(W), .SEC_LIMIT(60), .MIN_LIMIT(60), .HR_LIMIT(24)) dut (
        .Clk(Clk),
        .Clr(Clr),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_load_cyc = -10;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input logic [3:0] m);
        bus.Btn_Set = m[0];
        bus.Btn_Inc = m[1];
        bus.Btn_Dec = m[2];
        bus.Btn_Ok  = m[3];
    endtask

    // Mask bits: 0 Set, 1 Inc, 2 Dec, 3 Ok. Returns #1 after the edge where the FSM took the event.
    task automatic press(input logic [3:0] m);
        @(negedge Clk);
        drive(m);
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        drive(4'b0000);
        @(posedge Clk);
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_load(input logic [1:0] m, input int v);
        exp_t e;
        e.mode  = m;
        e.value = W'(v);
        exp_q.push_back(e);
    endtask

    task automatic set_cur(input int s, input int mi, input int h);
        bus.Cur_Sec = W'(s);
        bus.Cur_Min = W'(mi);
        bus.Cur_Hr  = W'(h);
    endtask

    // Monitor: every load pulse must match the next expected entry; bursts must be back-to-back.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            cyc++;
            if (bus.load) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_load_mode", int'(bus.mode), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("load_mode", int'(bus.mode), int'(e.mode));
                    chk("load_value", int'(bus.value), int'(e.value));
                    if (e.mode != MODE_SEC)
                        chk("load_consecutive", cyc - last_load_cyc, 1);
                end
                last_load_cyc = cyc;
            end else begin
                chk("idle_mode_value", int'({bus.mode, bus.value}), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(4'b0000);
        set_cur(0, 0, 0);

        // Reset held two cycles.
        Clr = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_enable", int'(bus.Enable), 1);
        chk("rst_load", int'(bus.load), 0);
        chk("rst_mode", int'(bus.mode), 0);
        chk("rst_value", int'(bus.value), 0);
        chk("rst_field", int'(bus.Field), 0);
        Clr = 1'b0;
        repeat (2) @(posedge Clk);

        // Edit hours up through the wrap, minutes down through the wrap, commit.
        set_cur(10, 5, 23);
        press(4'b0001);
        chk("seta_field_hr", int'(bus.Field), 3);
        chk("seta_enable", int'(bus.Enable), 0);
        press(4'b0010);
        press(4'b0001);
        chk("seta_field_min", int'(bus.Field), 2);
        repeat (6) press(4'b0100);
        expect_load(MODE_SEC, 10);
        expect_load(MODE_MIN, 59);
        expect_load(MODE_HR, 0);
        press(4'b1000);
        chk("seta_ld_enable", int'(bus.Enable), 0);
        chk("seta_ld_load", int'(bus.load), 1);
        repeat (3) @(posedge Clk);
        #1;
        chk("seta_run_enable", int'(bus.Enable), 1);
        chk("seta_run_field", int'(bus.Field), 0);

        // Seconds: decrement wraps from 0, simultaneous Inc+Dec is a no-op.
        set_cur(0, 30, 12);
        press(4'b0001);
        press(4'b0001);
        press(4'b0001);
        chk("setb_field_sec", int'(bus.Field), 1);
        press(4'b0100);
        press(4'b0110);
        expect_load(MODE_SEC, 59);
        expect_load(MODE_MIN, 30);
        expect_load(MODE_HR, 12);
        press(4'b1000);
        repeat (4) @(posedge Clk);

        // Ok with Inc in SET_MIN: no increment, burst starts right away.
        set_cur(1, 2, 3);
        press(4'b0001);
        press(4'b0001);
        chk("setc_field_min", int'(bus.Field), 2);
        expect_load(MODE_SEC, 1);
        expect_load(MODE_MIN, 2);
        expect_load(MODE_HR, 3);
        press(4'b1010);
        chk("setc_load_now", int'(bus.load), 1);
        chk("setc_mode_now", int'(bus.mode), 1);
        repeat (4) @(posedge Clk);

        // Reset during LD_MIN aborts the burst before the hours pulse.
        set_cur(4, 5, 6);
        press(4'b0001);
        expect_load(MODE_SEC, 4);
        expect_load(MODE_MIN, 5);
        press(4'b1000);
        @(posedge Clk);
        #1;
        chk("setd_in_ld_min", int'(bus.mode), 2);
        Clr = 1'b1;
        @(posedge Clk);
        #1;
        chk("setd_abort_enable", int'(bus.Enable), 1);
        chk("setd_abort_load", int'(bus.load), 0);
        Clr = 1'b0;
        repeat (4) @(posedge Clk);

        // Out-of-range captures clamp to 0; a held Inc counts once.
        set_cur(63, 60, 0);
        press(4'b0001);
        @(negedge Clk);
        bus.Btn_Inc = 1'b1;
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        bus.Btn_Inc = 1'b0;
        repeat (5) @(posedge Clk);
        expect_load(MODE_SEC, 0);
        expect_load(MODE_MIN, 0);
        expect_load(MODE_HR, 1);
        press(4'b1000);
        repeat (4) @(posedge Clk);

        // Hours decrement wraps 0 -> 23, minutes increment wraps 59 -> 0.
        set_cur(58, 59, 0);
        press(4'b0001);
        press(4'b0100);
        press(4'b0001);
        press(4'b0010);
        expect_load(MODE_SEC, 58);
        expect_load(MODE_MIN, 0);
        expect_load(MODE_HR, 23);
        press(4'b1000);
        repeat (6) @(posedge Clk);
        #1;
        chk("final_enable", int'(bus.Enable), 1);
        chk("pending_loads", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
